// File: rtl/ddp_pkg.sv
// Shared defaults for the data-driven pipeline stages and a constant-evaluable
// log2 helper used to size FIFO pointers.
package ddp_pkg;

    localparam int unsigned DFLT_PAYLOAD_W = 16;
    localparam int unsigned DFLT_SEL_W     = 2;
    localparam int unsigned DFLT_N_OUT     = 3;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bn_fifo.sv
// Synchronous FIFO with wrap-around pointers and a registered occupancy count.
// Head entry is presented combinationally on dout whenever the queue is non-empty.
module bn_fifo
    import ddp_pkg::*;
#(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   cnt_q;
    logic [PTR_W:0]   cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage carries no reset: an empty queue is never read by the consumer.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/bn_stage.sv
// Buffered N-way branch stage: queues {sel, payload} packets and routes each
// payload to its selected output channel; out-of-range selectors are dropped and counted.
module bn_stage
    import ddp_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = DFLT_PAYLOAD_W,
    parameter int unsigned SEL_W     = DFLT_SEL_W,
    parameter int unsigned N_OUT     = DFLT_N_OUT,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned ERR_W     = 8
) (
    input  logic                       CP,
    input  logic                       MR_N,
    input  logic                       Send_in,
    output logic                       Ack_out,
    input  logic [SEL_W+PAYLOAD_W-1:0] PACKET_IN,
    output logic [N_OUT-1:0]           Send_out,
    input  logic [N_OUT-1:0]           Ack_in,
    output logic [N_OUT*PAYLOAD_W-1:0] PACKET_OUT,
    output logic [ERR_W-1:0]           ERR_CNT
);

    localparam int unsigned    PKT_W    = SEL_W + PAYLOAD_W;
    localparam logic [SEL_W:0] N_OUT_EX = (SEL_W + 1)'(N_OUT);

    logic                             rdy_q;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic                             push;
    logic                             pop;
    logic [PKT_W-1:0]                 head;
    logic [SEL_W-1:0]                 head_sel;
    logic [PAYLOAD_W-1:0]             head_payload;
    logic                             sel_ok;
    logic                             drop;
    logic [N_OUT-1:0]                 hit;
    logic [N_OUT-1:0]                 load;
    logic [N_OUT-1:0]                 send_q;
    logic [N_OUT-1:0]                 send_d;
    logic [N_OUT-1:0][PAYLOAD_W-1:0]  out_q;
    logic [N_OUT-1:0][PAYLOAD_W-1:0]  out_d;
    logic [ERR_W-1:0]                 err_q;
    logic [ERR_W-1:0]                 err_d;

    // rdy_q keeps Ack_out low during reset and for the edge that releases it.
    assign Ack_out = rdy_q && !fifo_full;
    assign push    = Send_in && Ack_out;

    bn_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CP),
        .rst_n (MR_N),
        .push  (push),
        .pop   (pop),
        .din   (PACKET_IN),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_sel     = head[PKT_W-1 -: SEL_W];
    assign head_payload = head[PAYLOAD_W-1:0];
    assign sel_ok       = ({1'b0, head_sel} < N_OUT_EX);

    // Route decision on the head entry only; at most one channel loads per edge.
    always_comb begin
        hit  = '0;
        load = '0;
        pop  = 1'b0;
        drop = 1'b0;
        for (int k = 0; k < int'(N_OUT); k++) begin
            hit[k] = (head_sel == SEL_W'(k));
        end
        if (!fifo_empty) begin
            if (!sel_ok) begin
                pop  = 1'b1;
                drop = 1'b1;
            end else if (|(hit & (~send_q | Ack_in))) begin
                pop  = 1'b1;
                load = hit;
            end
        end
    end

    // A load wins over a drain, giving back-to-back transfers per channel.
    always_comb begin
        send_d = send_q;
        out_d  = out_q;
        for (int k = 0; k < int'(N_OUT); k++) begin
            if (load[k]) begin
                send_d[k] = 1'b1;
                out_d[k]  = head_payload;
            end else if (Ack_in[k]) begin
                send_d[k] = 1'b0;
            end
        end
    end

    always_comb begin
        err_d = err_q;
        if (drop && (err_q != '1)) err_d = err_q + ERR_W'(1);
    end

    always_ff @(posedge CP or negedge MR_N) begin
        if (!MR_N) begin
            rdy_q  <= 1'b0;
            send_q <= '0;
            out_q  <= '0;
            err_q  <= '0;
        end else begin
            rdy_q  <= 1'b1;
            send_q <= send_d;
            out_q  <= out_d;
            err_q  <= err_d;
        end
    end

    assign Send_out   = send_q;
    assign PACKET_OUT = out_q;
    assign ERR_CNT    = err_q;

endmodule

// File: tb/tb_bn_stage.sv
// Self-checking bench for bn_stage: directed tables and sequences plus random
// traffic compared every cycle against a queue-based reference model.
module tb_bn_stage;

    localparam int PW = 16;
    localparam int SW = 2;
    localparam int N  = 3;
    localparam int D  = 2;

    logic            CP        = 1'b0;
    logic            MR_N      = 1'b1;
    logic            Send_in   = 1'b0;
    logic [SW+PW-1:0] PACKET_IN = '0;
    logic [N-1:0]    Ack_in    = '0;

    logic            Ack_out;
    logic [N-1:0]    Send_out;
    logic [N*PW-1:0] PACKET_OUT;
    logic [7:0]      ERR_CNT;

    logic            Ack_out2;
    logic [N-1:0]    Send_out2;
    logic [N*PW-1:0] PACKET_OUT2;
    logic [1:0]      ERR_CNT2;

    bn_stage #(.PAYLOAD_W(PW), .SEL_W(SW), .N_OUT(N), .DEPTH(D), .ERR_W(8)) dut (
        .CP(CP), .MR_N(MR_N), .Send_in(Send_in), .Ack_out(Ack_out), .PACKET_IN(PACKET_IN),
        .Send_out(Send_out), .Ack_in(Ack_in), .PACKET_OUT(PACKET_OUT), .ERR_CNT(ERR_CNT)
    );

    // Same stimulus, narrow error counter to exercise saturation.
    bn_stage #(.PAYLOAD_W(PW), .SEL_W(SW), .N_OUT(N), .DEPTH(D), .ERR_W(2)) dut_sat (
        .CP(CP), .MR_N(MR_N), .Send_in(Send_in), .Ack_out(Ack_out2), .PACKET_IN(PACKET_IN),
        .Send_out(Send_out2), .Ack_in(Ack_in), .PACKET_OUT(PACKET_OUT2), .ERR_CNT(ERR_CNT2)
    );

    always #5 CP = ~CP;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [SW+PW-1:0] mq[$];
    bit [N-1:0]       m_so  = '0;
    logic [PW-1:0]    m_od [N];
    int               m_err = 0;
    bit               m_rdy = 1'b0;
    bit               mdl_en = 1'b0;

    task automatic model_reset();
        mq.delete();
        m_so  = '0;
        for (int k = 0; k < N; k++) m_od[k] = '0;
        m_err = 0;
        m_rdy = 1'b0;
    endtask

    task automatic model_step();
        int  s;
        int  ld;
        bit  acc;
        logic [PW-1:0] pl;
        acc = Send_in && m_rdy && (mq.size() < D);
        ld  = -1;
        pl  = '0;
        if (mq.size() > 0) begin
            s = int'(mq[0][SW+PW-1:PW]);
            if (s >= N) begin
                void'(mq.pop_front());
                m_err++;
            end else if (!m_so[s] || Ack_in[s]) begin
                pl = mq[0][PW-1:0];
                void'(mq.pop_front());
                ld = s;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (k == ld) begin
                m_so[k] = 1'b1;
                m_od[k] = pl;
            end else if (Ack_in[k]) begin
                m_so[k] = 1'b0;
            end
        end
        if (acc) mq.push_back(PACKET_IN);
        m_rdy = 1'b1;
    endtask

    task automatic model_check();
        int e8;
        int e2;
        e8 = (m_err > 255) ? 255 : m_err;
        e2 = (m_err > 3) ? 3 : m_err;
        chk("m_send_out", 64'(Send_out), 64'(m_so));
        chk("m_send_out_sat", 64'(Send_out2), 64'(m_so));
        chk("m_ack_out", 64'(Ack_out), 64'(m_rdy && (mq.size() < D)));
        chk("m_ack_out_sat", 64'(Ack_out2), 64'(m_rdy && (mq.size() < D)));
        for (int k = 0; k < N; k++) begin
            chk($sformatf("m_packet_out[%0d]", k), 64'(PACKET_OUT[k*PW +: PW]), 64'(m_od[k]));
            chk($sformatf("m_packet_out_sat[%0d]", k), 64'(PACKET_OUT2[k*PW +: PW]),
                64'(m_od[k]));
        end
        chk("m_err_cnt", 64'(ERR_CNT), 64'(e8));
        chk("m_err_cnt_sat", 64'(ERR_CNT2), 64'(e2));
    endtask

    always @(posedge CP or negedge MR_N) begin
        if (!MR_N) model_reset();
        else model_step();
    end

    always @(negedge CP) begin
        if (mdl_en) model_check();
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic             send;
        logic [SW+PW-1:0] pkt;
        logic [N-1:0]     ack;
        logic [N-1:0]     exp_so;
        logic             exp_ack;
        int               exp_ch;
        logic [PW-1:0]    exp_d;
        int               exp_err;
    } vec_t;

    vec_t tbl[$];

    task automatic step();
        @(posedge CP);
        #1;
    endtask

    initial begin
        // Streaming 0,1,2,0,1,2 with continuous acks.
        tbl.push_back('{1'b1, {2'd0, 16'h1000}, 3'b111, 3'b000, 1'b1, -1, 16'h0,    0});
        tbl.push_back('{1'b1, {2'd1, 16'h1001}, 3'b111, 3'b001, 1'b1,  0, 16'h1000, 0});
        tbl.push_back('{1'b1, {2'd2, 16'h1002}, 3'b111, 3'b010, 1'b1,  1, 16'h1001, 0});
        tbl.push_back('{1'b1, {2'd0, 16'h1003}, 3'b111, 3'b100, 1'b1,  2, 16'h1002, 0});
        tbl.push_back('{1'b1, {2'd1, 16'h1004}, 3'b111, 3'b001, 1'b1,  0, 16'h1003, 0});
        tbl.push_back('{1'b1, {2'd2, 16'h1005}, 3'b111, 3'b010, 1'b1,  1, 16'h1004, 0});
        tbl.push_back('{1'b0, 18'h0,            3'b111, 3'b100, 1'b1,  2, 16'h1005, 0});
        tbl.push_back('{1'b0, 18'h0,            3'b111, 3'b000, 1'b1, -1, 16'h0,    0});
        // Head-of-line blocking on channel 0.
        tbl.push_back('{1'b1, {2'd0, 16'hA000}, 3'b110, 3'b000, 1'b1, -1, 16'h0,    0});
        tbl.push_back('{1'b1, {2'd0, 16'hB000}, 3'b110, 3'b001, 1'b1,  0, 16'hA000, 0});
        tbl.push_back('{1'b1, {2'd1, 16'hC000}, 3'b110, 3'b001, 1'b0,  0, 16'hA000, 0});
        tbl.push_back('{1'b0, 18'h0,            3'b110, 3'b001, 1'b0,  0, 16'hA000, 0});
        tbl.push_back('{1'b0, 18'h0,            3'b111, 3'b001, 1'b1,  0, 16'hB000, 0});
        tbl.push_back('{1'b0, 18'h0,            3'b111, 3'b010, 1'b1,  1, 16'hC000, 0});
        tbl.push_back('{1'b0, 18'h0,            3'b111, 3'b000, 1'b1, -1, 16'h0,    0});
        // Back-to-back pair on channel 1.
        tbl.push_back('{1'b1, {2'd1, 16'h1111}, 3'b111, 3'b000, 1'b1, -1, 16'h0,    0});
        tbl.push_back('{1'b1, {2'd1, 16'h2222}, 3'b111, 3'b010, 1'b1,  1, 16'h1111, 0});
        tbl.push_back('{1'b0, 18'h0,            3'b111, 3'b010, 1'b1,  1, 16'h2222, 0});
        tbl.push_back('{1'b0, 18'h0,            3'b111, 3'b000, 1'b1, -1, 16'h0,    0});
        // Out-of-range selector is dropped.
        tbl.push_back('{1'b1, {2'd3, 16'hDEAD}, 3'b111, 3'b000, 1'b1, -1, 16'h0,    0});
        tbl.push_back('{1'b0, 18'h0,            3'b111, 3'b000, 1'b1, -1, 16'h0,    1});
        tbl.push_back('{1'b0, 18'h0,            3'b111, 3'b000, 1'b1, -1, 16'h0,    1});

        // ---- reset, then reset mid-stream ----
        #1 MR_N = 1'b0;
        mdl_en = 1'b1;
        step();
        chk("rst_send_out", 64'(Send_out), 64'h0);
        chk("rst_ack_out", 64'(Ack_out), 64'h0);
        chk("rst_err_cnt", 64'(ERR_CNT), 64'h0);
        MR_N = 1'b1;
        #1 chk("rst_ack_before_edge", 64'(Ack_out), 64'h0);
        step();
        chk("rst_ack_after_edge", 64'(Ack_out), 64'h1);

        Ack_in = 3'b000;
        for (int i = 0; i < 3; i++) begin
            Send_in   = 1'b1;
            PACKET_IN = {2'd1, 16'h00A1 + 16'(i)};
            step();
        end
        Send_in = 1'b0;
        chk("mid_send_out_busy", 64'(Send_out), 64'h2);
        chk("mid_ack_full", 64'(Ack_out), 64'h0);
        #2 MR_N = 1'b0;
        #1;
        chk("mid_rst_send_out", 64'(Send_out), 64'h0);
        chk("mid_rst_ack_out", 64'(Ack_out), 64'h0);
        chk("mid_rst_packet_out", 64'(PACKET_OUT), 64'h0);
        Ack_in = 3'b111;
        step();
        step();
        chk("mid_rst_hold_ack", 64'(Ack_out), 64'h0);
        MR_N = 1'b1;
        #1 chk("mid_rel_ack_before_edge", 64'(Ack_out), 64'h0);
        step();
        chk("mid_rel_ack_after_edge", 64'(Ack_out), 64'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_stale_packet", 64'(Send_out), 64'h0);
        end

        // ---- single packet to channel 2 ----
        Send_in   = 1'b1;
        PACKET_IN = {2'd2, 16'hBEEF};
        step();
        Send_in = 1'b0;
        chk("single_not_yet", 64'(Send_out), 64'h0);
        step();
        chk("single_send_out", 64'(Send_out), 64'h4);
        chk("single_payload", 64'(PACKET_OUT[47:32]), 64'hBEEF);
        step();
        chk("single_cleared", 64'(Send_out), 64'h0);
        chk("single_retained", 64'(PACKET_OUT[47:32]), 64'hBEEF);

        // ---- table ----
        foreach (tbl[i]) begin
            Send_in   = tbl[i].send;
            PACKET_IN = tbl[i].pkt;
            Ack_in    = tbl[i].ack;
            step();
            chk($sformatf("tbl%0d_send_out", i), 64'(Send_out), 64'(tbl[i].exp_so));
            chk($sformatf("tbl%0d_ack_out", i), 64'(Ack_out), 64'(tbl[i].exp_ack));
            chk($sformatf("tbl%0d_err_cnt", i), 64'(ERR_CNT), 64'(tbl[i].exp_err));
            if (tbl[i].exp_ch >= 0)
                chk($sformatf("tbl%0d_payload", i), 64'(PACKET_OUT[tbl[i].exp_ch*PW +: PW]),
                    64'(tbl[i].exp_d));
        end

        // ---- four more drops: 5 total, narrow counter saturates ----
        for (int i = 0; i < 4; i++) begin
            Send_in   = 1'b1;
            PACKET_IN = {2'd3, 16'(i)};
            step();
            chk("drop_no_send", 64'(Send_out), 64'h0);
        end
        Send_in = 1'b0;
        step();
        step();
        chk("drop_err_cnt", 64'(ERR_CNT), 64'd5);
        chk("drop_err_cnt_sat", 64'(ERR_CNT2), 64'd3);

        // ---- random traffic ----
        for (int c = 0; c < 3000; c++) begin
            int ack_pct;
            ack_pct = ((c / 500) % 3 == 0) ? 90 : (((c / 500) % 3 == 1) ? 50 : 20);
            Send_in   = ($urandom_range(0, 3) != 0);
            PACKET_IN = {2'($urandom_range(0, 3)), 16'($urandom)};
            for (int k = 0; k < N; k++) Ack_in[k] = ($urandom_range(0, 99) < ack_pct);
            if (c == 1700) begin
                #2 MR_N = 1'b0;
                step();
                MR_N = 1'b1;
            end else begin
                step();
            end
        end
        Send_in = 1'b0;
        Ack_in  = 3'b111;
        repeat (4) step();
        chk("final_drained", 64'(Send_out), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bn_stage.md
Name: bn_stage

Overview:
- Parametrised, clocked successor to the two-way branch stage in the data-driven pipeline.
- Accepts packets over a Send/Ack handshake and buffers them in a DEPTH-entry input queue.
- Strips a SEL_W-bit selector field and routes the payload to one of N_OUT output channels, each with its own Send/Ack handshake and output register.
- Packets whose selector is out of range are dropped and counted.

Parameters:
- PAYLOAD_W, 16: payload width; PACKET_IN is {SEL, PAYLOAD}.
- SEL_W, 2: selector width; must satisfy N_OUT <= 2**SEL_W.
- N_OUT, 3: number of output channels (2..2**SEL_W).
- DEPTH, 2: input queue depth (power of two, >= 2).
- ERR_W, 8: width of the drop counter.

Ports:
- CP  input  1  clock; all state updates on the rising edge.
- MR_N  input  1  reset; asynchronous, active-low.
- Send_in  input  1  upstream packet valid.
- Ack_out  output  1  stage can accept; transfer occurs when Send_in && Ack_out at a CP edge.
- PACKET_IN  input  SEL_W+PAYLOAD_W  selector in the MSBs, payload below.
- Send_out  output  N_OUT  per-channel packet valid.
- Ack_in  input  N_OUT  per-channel downstream accept.
- PACKET_OUT  output  N_OUT*PAYLOAD_W  channel k occupies bits [k*PAYLOAD_W +: PAYLOAD_W].
- ERR_CNT  output  ERR_W  saturating count of dropped packets.

Behaviour:
- Reset (MR_N low, asynchronous):
  - Queue empties; all output registers are cleared to 0.
  - Send_out = 0, Ack_out = 0 while MR_N is low; Ack_out = 1 on the first edge after release.
  - ERR_CNT = 0. Packets in flight are discarded, with no partial outputs.
- Input side:
  - Ack_out = !full, derived from a registered occupancy count (combinational from state only, never from Send_in).
  - No accept when full, even if the head is popped in the same cycle.
  - Queue is FIFO with wrap-around pointers of width log2(DEPTH); occupancy is log2(DEPTH)+1 bits.
- Route step (every edge, if queue not empty), with head selector s:
  - s >= N_OUT: pop head, discard it, ERR_CNT += 1 (saturates at all-ones).
  - Else, if channel s is free (!Send_out[s], or Send_out[s] && Ack_in[s] this cycle): pop head, load payload into OUT_REG[s], set Send_out[s] = 1.
  - Else: hold. Head-of-line blocking is intended; packets are never reordered.
- Output side, per channel k:
  - Send_out[k] clears on an edge where Ack_in[k] is high and no new load targets k.
  - Load plus drain on the same edge leaves Send_out[k] = 1 with the new payload (back-to-back, 1 packet/cycle/channel).
  - PACKET_OUT[k] holds its value while Send_out[k] = 1; it is stable and retains the last payload after drain.
  - Ack_in[k] while Send_out[k] = 0 is ignored.
- Latency and throughput:
  - Accepted at edge t, the packet is visible on Send_out at edge t+1 (2-register path: queue, then output register).
  - Sustained throughput is 1 packet/cycle when downstream acks continuously and selectors are valid.
- Simultaneous events: a push and a pop on the same edge keep occupancy unchanged. An empty queue is never popped.
- Route decisions are made only on the head entry. At most one channel is loaded per edge.

Decomposition:
- Package ddp_pkg holds the default widths (PAYLOAD_W, SEL_W, N_OUT) and a function clog2 for pointer sizing.
- One sub-module, bn_fifo: synchronous FIFO parametrised by width and depth.
  - Ports: push, pop, din, dout, full, empty.
  - Asynchronous active-low reset.
- Routing, output registers and the error counter live in bn_stage.

Test Plan:
1. Reset, then hold MR_N low mid-stream with 2 packets queued and Send_out[1] = 1 → all Send_out = 0, Ack_out = 0, ERR_CNT = 0; Ack_out = 1 one edge after release; no stale packet emitted.
2. Single packet {SEL=2, 0xBEEF}, all Ack_in = 1 → Send_out = 3'b100 one edge after accept, PACKET_OUT[47:32] = 0xBEEF; cleared on the next edge.
3. Streaming selectors 0,1,2,0,1,2 with Ack_in all high every cycle → one packet per cycle out, correct channel and order; Ack_out never drops.
4. Ack_in[0] = 0, then push SEL=0,0,1 → first packet sits on channel 0, second blocks at the head, third is held behind it (Ack_out goes 0 when DEPTH = 2 is full); raising Ack_in[0] releases them in order and channel 1 receives the third.
5. Push SEL=3 (N_OUT = 3) → packet dropped, no Send_out pulse, ERR_CNT = 1; with ERR_W = 2, 5 drops → ERR_CNT saturates at 3.
6. Back-to-back pair to channel 1 with Ack_in[1] = 1 → Send_out[1] stays high for 2 consecutive cycles with payloads A then B; the load+drain edge loses nothing.
